// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard and forwarding unit for the five-stage MIPS pipeline.
// A small scoreboard tracks {valid, waddr, tnew} for every in-flight
// instruction from E to W. Decode read ports are resolved against it to
// produce forwarded operands, per-port readiness and a single stall request.
// Optional feature: define FWD_PERF_CNT_EN to build the stall-cycle counter;
// otherwise perf_stall_cnt is tied to zero.
module fwd_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TNEW_W  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        D_wen,
  input  logic [ADDR_W-1:0]           D_waddr,
  input  logic [TNEW_W-1:0]           D_tnew,
  input  logic [NUM_SRC*ADDR_W-1:0]   D_raddr,
  input  logic [NUM_SRC*TNEW_W-1:0]   D_tuse,
  input  logic [NUM_SRC*DATA_W-1:0]   D_rfdata,
  input  logic [DEPTH*DATA_W-1:0]     stg_data,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC-1:0]          fwd_ready,
  output logic                        stall,
  output logic [31:0]                 perf_stall_cnt
);

  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_waddr [DEPTH];
  logic [TNEW_W-1:0] ent_tnew  [DEPTH];
  logic [NUM_SRC-1:0] port_stall;

  // Tnew counts down as an entry ages and saturates at zero
  function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Resolve every read port; scanning oldest to youngest lets the youngest match win
  always_comb begin
    fwd_data   = D_rfdata;
    fwd_ready  = '1;
    port_stall = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_valid[k] &&
            (D_raddr[i*ADDR_W +: ADDR_W] != '0) &&
            (ent_waddr[k] == D_raddr[i*ADDR_W +: ADDR_W])) begin
          fwd_data[i*DATA_W +: DATA_W] = stg_data[k*DATA_W +: DATA_W];
          fwd_ready[i]  = (ent_tnew[k] == '0);
          port_stall[i] = (ent_tnew[k] > D_tuse[i*TNEW_W +: TNEW_W]);
        end
      end
    end
  end

  assign stall = |port_stall;

  // Age the E..W pipeline every cycle and insert the D instruction or a bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_waddr[k] <= '0;
        ent_tnew[k]  <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_waddr[k] <= ent_waddr[k-1];
        ent_tnew[k]  <= age_tnew(ent_tnew[k-1]);
      end
      ent_valid[0] <= !stall && D_wen && (D_waddr != '0);
      ent_waddr[0] <= D_waddr;
      ent_tnew[0]  <= D_tnew;
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Count cycles spent stalling; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if (stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed testbench for fwd_scoreboard (default parameters).
module tb_fwd_scoreboard;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;
  localparam logic [31:0] S0  = 32'hAAAA_0000;
  localparam logic [31:0] S1  = 32'h0000_1234;
  localparam logic [31:0] S2  = 32'h0000_5678;

`ifdef FWD_PERF_CNT_EN
  localparam logic [31:0] PERF_BEFORE_RESET = 32'd4;
  localparam logic [31:0] PERF_AFTER_LOOP   = 32'd3;
`else
  localparam logic [31:0] PERF_BEFORE_RESET = 32'd0;
  localparam logic [31:0] PERF_AFTER_LOOP   = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        D_wen;
  logic [4:0]  D_waddr;
  logic [1:0]  D_tnew;
  logic [9:0]  D_raddr;
  logic [3:0]  D_tuse;
  logic [63:0] D_rfdata;
  logic [95:0] stg_data;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_ready;
  logic        stall;
  logic [31:0] perf_stall_cnt;

  int num_compared;
  int num_mismatched;

  fwd_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .D_wen          (D_wen),
    .D_waddr        (D_waddr),
    .D_tnew         (D_tnew),
    .D_raddr        (D_raddr),
    .D_tuse         (D_tuse),
    .D_rfdata       (D_rfdata),
    .stg_data       (stg_data),
    .fwd_data       (fwd_data),
    .fwd_ready      (fwd_ready),
    .stall          (stall),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [4:0] waddr,
                               input logic [1:0] tnew,
                               input logic [4:0] ra0, input logic [1:0] tu0,
                               input logic [4:0] ra1, input logic [1:0] tu1);
    D_wen   = wen;
    D_waddr = waddr;
    D_tnew  = tnew;
    D_raddr = {ra1, ra0};
    D_tuse  = {tu1, tu0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    reset    = 1'b0;
    D_rfdata = {RF1, RF0};
    stg_data = {S2, S1, S0};
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    tick();
    reset = 1'b1;

    // reset state
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd3, 2'd0, 5'd4, 2'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_ready", {30'd0, fwd_ready}, 32'd3);
    checkOutput("rst_fwd0", fwd_data[31:0], RF0);
    checkOutput("rst_fwd1", fwd_data[63:32], RF1);
    checkOutput("rst_perf", perf_stall_cnt, 32'd0);

    // ALU-use: addu $8 (tnew 1), then beq reading $8 with tuse 0
    applyStimulus(1'b1, 5'd8, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    checkOutput("alu_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd0);
    checkOutput("alu_stall", {31'd0, stall}, 32'd1);
    checkOutput("alu_stall_ready", {30'd0, fwd_ready}, 32'd2);
    tick();
    checkOutput("alu_after_stall", {31'd0, stall}, 32'd0);
    checkOutput("alu_fwd", fwd_data[31:0], S1);
    checkOutput("alu_ready", {30'd0, fwd_ready}, 32'd3);
    tick();

    // Load-use: lw $9 (tnew 2), addu $10 reads $9 with tuse 1
    applyStimulus(1'b1, 5'd9, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd10, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0);
    checkOutput("ld_stall", {31'd0, stall}, 32'd1);
    checkOutput("ld_stall_ready", {30'd0, fwd_ready}, 32'd2);
    tick();
    checkOutput("ld_nostall", {31'd0, stall}, 32'd0);
    checkOutput("ld_notready", {30'd0, fwd_ready}, 32'd2);
    tick();
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd9, 2'd0, 5'd10, 2'd1);
    checkOutput("ld_fwd_w", fwd_data[31:0], S2);
    checkOutput("ld_fwd_e", fwd_data[63:32], S0);
    checkOutput("ld_ready_mix", {30'd0, fwd_ready}, 32'd1);
    checkOutput("ld_mix_stall", {31'd0, stall}, 32'd0);
    tick();

    // $0: writes are never tracked, reads come from the RF
    D_rfdata = {RF1, 32'd0};
    applyStimulus(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checkOutput("r0_fwd", fwd_data[31:0], 32'd0);
    checkOutput("r0_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("r0_ready", {30'd0, fwd_ready}, 32'd3);
    D_rfdata = {RF1, RF0};

    // Shadowing: $5 ready in entry 2, $5 tnew 1 in entry 0
    applyStimulus(1'b1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0);
    checkOutput("shadow_stall", {31'd0, stall}, 32'd1);
    checkOutput("shadow_ready", {30'd0, fwd_ready}, 32'd2);
    tick();
    checkOutput("shadow_after", {31'd0, stall}, 32'd0);
    checkOutput("shadow_fwd", fwd_data[31:0], S1);
    tick();

    // Two-port conflict: only rt matches a tnew 2 entry
    applyStimulus(1'b1, 5'd12, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd13, 2'd1, 5'd6, 2'd0, 5'd12, 2'd0);
    checkOutput("two_stall", {31'd0, stall}, 32'd1);
    checkOutput("two_rs_fwd", fwd_data[31:0], RF0);
    checkOutput("two_ready", {30'd0, fwd_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd13, 2'd0, 5'd0, 2'd0);
    checkOutput("two_not_inserted", {31'd0, stall}, 32'd0);
    checkOutput("two_ni_fwd", fwd_data[31:0], RF0);
    checkOutput("two_ni_ready", {30'd0, fwd_ready}, 32'd3);
    tick();

    // Reset mid-operation with valid entries
    applyStimulus(1'b1, 5'd14, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd15, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    checkOutput("perf_before_reset", perf_stall_cnt, PERF_BEFORE_RESET);
    applyStimulus(1'b1, 5'd16, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd14, 2'd0, 5'd16, 2'd0);
    checkOutput("mid_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("mid_rst_fwd0", fwd_data[31:0], RF0);
    checkOutput("mid_rst_fwd1", fwd_data[63:32], RF1);
    checkOutput("mid_rst_ready", {30'd0, fwd_ready}, 32'd3);
    checkOutput("mid_rst_perf", perf_stall_cnt, 32'd0);
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd15, 2'd0, 5'd0, 2'd0);
    checkOutput("mid_rst_r15", {31'd0, stall}, 32'd0);

    // Three stall cycles from a tnew 3 entry that ages out of W
    applyStimulus(1'b1, 5'd7, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0);
      checkOutput($sformatf("long_stall%0d", c), {31'd0, stall}, 32'd1);
      tick();
    end
    checkOutput("long_release", {31'd0, stall}, 32'd0);
    checkOutput("long_fwd", fwd_data[31:0], RF0);
    checkOutput("perf_count", perf_stall_cnt, PERF_AFTER_LOOP);
    tick();
    checkOutput("perf_hold", perf_stall_cnt, PERF_AFTER_LOOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
